// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: decodes opcode/funct and sequences the datapath enables and selects.
// Define MIPS_CTRL_IMM_LOGIC_EN to route andi/ori through the IMMEX/IMMWB states.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
        TRAP   = 4'd12, IMMEX  = 4'd13, IMMWB  = 4'd14
    } state_t;

    typedef struct packed {
        logic [3:0] alu;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       i_or_d;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       trap;
    } ctrl_t;

    // ALU operation implied by the instruction held in IR (R-type funct or immediate logic op).
    function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] a;
        a = 4'b0010;
        if (op == 6'h00) begin
            case (fn)
                6'h20:   a = 4'b0010;
                6'h22:   a = 4'b0110;
                6'h24:   a = 4'b0000;
                6'h25:   a = 4'b0001;
                6'h2A:   a = 4'b0111;
                default: a = 4'b0010;
            endcase
        end else if (op == 6'h0C) begin
            a = 4'b0000;
        end else if (op == 6'h0D) begin
            a = 4'b0001;
        end else begin
            a = 4'b0010;
        end
        return a;
    endfunction

    // Moore control word for a state; registered so outputs follow the state register.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] op_alu);
        ctrl_t c;
        c     = '0;
        c.alu = 4'b0010;
        case (s)
            FETCH:  begin c.mem_read = 1'b1; c.src_b = 2'b01; end
            DECODE: c.src_b = 2'b11;
            MEMADR: begin c.src_a = 1'b1; c.src_b = 2'b10; end
            MEMRD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEMWR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            EXEC:   begin c.src_a = 1'b1; c.alu = op_alu; end
            ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            BRANCH: begin c.src_a = 1'b1; c.alu = 4'b0110; c.pc_src = 2'b01; end
            ADDIEX: begin c.src_a = 1'b1; c.src_b = 2'b10; end
            ADDIWB: c.reg_write = 1'b1;
            JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            TRAP:   c.trap = 1'b1;
`ifdef MIPS_CTRL_IMM_LOGIC_EN
            IMMEX:  begin c.src_a = 1'b1; c.src_b = 2'b10; c.alu = op_alu; end
            IMMWB:  c.reg_write = 1'b1;
`endif
            default: c.alu = 4'b0010;
        endcase
        return c;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] next_cnt_s;
    ctrl_t            ctrl_r;
    logic             timeout_s;
    logic             rtype_ok_s;

    assign timeout_s  = (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rtype_ok_s = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                        (funct == 6'h25) || (funct == 6'h2A);

    // Next-state and wait-counter logic; the counter only survives while a state keeps waiting.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = '0;
        case (state_r)
            FETCH, MEMRD, MEMWR: begin
                if (mem_ready) begin
                    if (state_r == FETCH) begin
                        next_state_s = DECODE;
                    end else if (state_r == MEMRD) begin
                        next_state_s = MEMWB;
                    end else begin
                        next_state_s = FETCH;
                    end
                end else if (timeout_s) begin
                    next_state_s = TRAP;
                end else begin
                    next_state_s = state_r;
                    next_cnt_s   = wait_cnt_r + CNT_W'(1);
                end
            end
            DECODE: begin
                case (opcode)
                    6'h23, 6'h2B: next_state_s = MEMADR;
                    6'h00:        next_state_s = rtype_ok_s ? EXEC : TRAP;
                    6'h04:        next_state_s = BRANCH;
                    6'h08:        next_state_s = ADDIEX;
                    6'h02:        next_state_s = JUMP;
`ifdef MIPS_CTRL_IMM_LOGIC_EN
                    6'h0C, 6'h0D: next_state_s = IMMEX;
`endif
                    default:      next_state_s = TRAP;
                endcase
            end
            MEMADR: begin
                if (opcode == 6'h23) begin
                    next_state_s = MEMRD;
                end else if (opcode == 6'h2B) begin
                    next_state_s = MEMWR;
                end else begin
                    next_state_s = TRAP;
                end
            end
            EXEC:   next_state_s = ALUWB;
            ADDIEX: next_state_s = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: next_state_s = FETCH;
            TRAP:   next_state_s = TRAP;
`ifdef MIPS_CTRL_IMM_LOGIC_EN
            IMMEX:  next_state_s = IMMWB;
            IMMWB:  next_state_s = FETCH;
`endif
            default: next_state_s = TRAP;
        endcase
    end

    // State, wait counter and registered control word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= FETCH;
            wait_cnt_r <= '0;
            ctrl_r     <= decode_ctrl(FETCH, 4'b0010);
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= next_cnt_s;
            ctrl_r     <= decode_ctrl(next_state_s, alu_of(opcode, funct));
        end
    end

    assign alu_control = ctrl_r.alu;
    assign alu_src_a   = ctrl_r.src_a;
    assign alu_src_b   = ctrl_r.src_b;
    assign pc_src      = ctrl_r.pc_src;
    assign i_or_d      = ctrl_r.i_or_d;
    assign reg_dst     = ctrl_r.reg_dst;
    assign mem_to_reg  = ctrl_r.mem_to_reg;
    assign trap        = ctrl_r.trap;
    assign state       = state_r;

    // Enables are held low for the whole reset window, including the Mealy fetch/branch terms.
    assign mem_read  = ctrl_r.mem_read  & ~rst;
    assign mem_write = ctrl_r.mem_write & ~rst;
    assign reg_write = ctrl_r.reg_write & ~rst;
    assign ir_write  = ~rst & (state_r == FETCH) & mem_ready;
    assign pc_write  = ~rst & (ctrl_r.pc_write |
                               ((state_r == FETCH) & mem_ready) |
                               ((state_r == BRANCH) & zero));

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_mips_multicycle_ctrl;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct  = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       i_or_d, reg_dst, mem_to_reg, trap;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int m_state = 0;
    int m_cnt   = 0;

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .i_or_d(i_or_d),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit is_rfunct(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    function automatic bit waits(input int s);
        return s == 0 || s == 3 || s == 5;
    endfunction

    // Model: next state from the instruction rules.
    function automatic int model_next(input int s, input int cnt, input logic [5:0] op,
                                      input logic [5:0] fn, input logic mr);
        if (waits(s)) begin
            if (mr) return (s == 0) ? 1 : ((s == 3) ? 4 : 0);
            if (cnt + 1 >= TIMEOUT) return 12;
            return s;
        end
        if (s == 1) begin
            if (op == 6'h23 || op == 6'h2B) return 2;
            if (op == 6'h00) return is_rfunct(fn) ? 6 : 12;
            if (op == 6'h04) return 8;
            if (op == 6'h08) return 9;
            if (op == 6'h02) return 11;
`ifdef MIPS_CTRL_IMM_LOGIC_EN
            if (op == 6'h0C || op == 6'h0D) return 13;
`endif
            return 12;
        end
        if (s == 2) return (op == 6'h23) ? 3 : 5;
        if (s == 6) return 7;
        if (s == 9) return 10;
        if (s == 13) return 14;
        if (s == 4 || s == 7 || s == 8 || s == 10 || s == 11 || s == 14) return 0;
        return 12;
    endfunction

    function automatic int model_cnt(input int s, input int cnt, input logic mr);
        if (waits(s) && !mr && cnt + 1 < TIMEOUT) return cnt + 1;
        return 0;
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    // {alu, src_a, src_b, pc_src, mem_read, mem_write, reg_write, i_or_d, reg_dst, mem_to_reg, trap}
    function automatic logic [15:0] base_vec(input int s, input logic [5:0] op, input logic [5:0] fn);
        case (s)
            0:  return {4'b0010, 1'b0, 2'b01, 2'b00, 7'b1000000};
            1:  return {4'b0010, 1'b0, 2'b11, 2'b00, 7'b0000000};
            2:  return {4'b0010, 1'b1, 2'b10, 2'b00, 7'b0000000};
            3:  return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b1001000};
            4:  return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0010010};
            5:  return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0101000};
            6:  return {funct_alu(fn), 1'b1, 2'b00, 2'b00, 7'b0000000};
            7:  return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0010100};
            8:  return {4'b0110, 1'b1, 2'b00, 2'b01, 7'b0000000};
            9:  return {4'b0010, 1'b1, 2'b10, 2'b00, 7'b0000000};
            10: return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0010000};
            11: return {4'b0010, 1'b0, 2'b00, 2'b10, 7'b0000000};
            12: return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0000001};
            13: return {(op == 6'h0C) ? 4'b0000 : 4'b0001, 1'b1, 2'b10, 2'b00, 7'b0000000};
            14: return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0010000};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [21:0] model_out(input int s, input logic [5:0] op, input logic [5:0] fn,
                                              input logic mr, input logic z, input logic r);
        logic [15:0] v;
        logic pcw, irw;
        v   = base_vec(s, op, fn);
        pcw = (s == 11) || (s == 0 && mr) || (s == 8 && z);
        irw = (s == 0 && mr);
        if (r) begin
            v[6] = 1'b0; v[5] = 1'b0; v[4] = 1'b0; pcw = 1'b0; irw = 1'b0;
        end
        return {v, pcw, irw, 4'(s)};
    endfunction

    logic [21:0] got_all;
    assign got_all = {alu_control, alu_src_a, alu_src_b, pc_src, mem_read, mem_write, reg_write,
                      i_or_d, reg_dst, mem_to_reg, trap, pc_write, ir_write, state};

    // Model state advance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_cnt   <= 0;
        end else begin
            m_state <= model_next(m_state, m_cnt, opcode, funct, mem_ready);
            m_cnt   <= model_cnt(m_state, m_cnt, mem_ready);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (got_all !== model_out(m_state, opcode, funct, mem_ready, zero, rst)) begin
                errors++;
                $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, got_all,
                         model_out(m_state, opcode, funct, mem_ready, zero, rst));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic mr, input logic z);
        @(posedge clk);
        #1;
        mem_ready = mr;
        zero      = z;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        cyc(1'b1, 1'b0);
        chk("fetch_state", state, 0);
        cyc(1'b0, 1'b0);
        chk("decode_state", state, 1);
    endtask

    logic [5:0] fns  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [3:0] alus [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    initial begin
        #1 rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_mem_read", mem_read, 0);
        chk("reset_trap", trap, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_mem_read", mem_read, 1);

        // R-type: add, sub, and, or, slt
        for (int i = 0; i < 5; i++) begin
            opcode = 6'h00; funct = fns[i];
            cyc(1'b1, 1'b0);
            chk("rtype_fetch_pc_write", pc_write, 1);
            chk("rtype_fetch_ir_write", ir_write, 1);
            cyc(1'b0, 1'b0); chk("rtype_decode", state, 1);
            cyc(1'b0, 1'b0); chk("rtype_exec", state, 6);
            chk("rtype_alu", alu_control, alus[i]);
            chk("rtype_exec_no_write", reg_write, 0);
            cyc(1'b0, 1'b0); chk("rtype_aluwb", state, 7);
            chk("rtype_aluwb_write", reg_write, 1);
        end

        // lw with three stalled MEMRD cycles
        start_instr(6'h23, 6'h00);
        cyc(1'b0, 1'b0); chk("lw_memadr", state, 2);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0); chk("lw_memrd_wait", state, 3);
        end
        cyc(1'b1, 1'b0); chk("lw_memrd_done", state, 3);
        cyc(1'b0, 1'b0); chk("lw_memwb", state, 4);
        chk("lw_mem_to_reg", mem_to_reg, 1);
        chk("lw_no_trap", trap, 0);

        // sw
        start_instr(6'h2B, 6'h00);
        cyc(1'b0, 1'b0); chk("sw_memadr", state, 2);
        cyc(1'b1, 1'b0); chk("sw_memwr", state, 5);
        chk("sw_mem_write", mem_write, 1);

        // beq taken then not taken
        start_instr(6'h04, 6'h00);
        cyc(1'b0, 1'b1); chk("beq_state", state, 8);
        chk("beq_taken_pc_write", pc_write, 1);
        chk("beq_pc_src", pc_src, 1);
        start_instr(6'h04, 6'h00);
        cyc(1'b0, 1'b0); chk("beq_nt_pc_write", pc_write, 0);

        // addi and j
        start_instr(6'h08, 6'h00);
        cyc(1'b0, 1'b0); chk("addi_ex", state, 9);
        cyc(1'b0, 1'b0); chk("addi_wb", state, 10);
        chk("addi_reg_write", reg_write, 1);
        start_instr(6'h02, 6'h00);
        cyc(1'b0, 1'b0); chk("jump_state", state, 11);
        chk("jump_pc_write", pc_write, 1);
        chk("jump_pc_src", pc_src, 2);

        // reset in the middle of a store
        start_instr(6'h2B, 6'h00);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0); chk("sw2_memwr", state, 5);
        chk("sw2_mem_write", mem_write, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_mem_write", mem_write, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // ori: immediate path or trap depending on build
        start_instr(6'h0D, 6'h00);
        cyc(1'b0, 1'b0);
`ifdef MIPS_CTRL_IMM_LOGIC_EN
        chk("ori_immex", state, 13);
        chk("ori_alu", alu_control, 4'b0001);
        cyc(1'b0, 1'b0); chk("ori_immwb", state, 14);
        chk("ori_reg_write", reg_write, 1);
`else
        chk("ori_trap", state, 12);
        chk("ori_trap_flag", trap, 1);
`endif
        do_reset();

        // illegal opcode: sticky trap, no enables even with mem_ready high
        start_instr(6'h3F, 6'h00);
        cyc(1'b0, 1'b0); chk("illop_trap", state, 12);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1);
            chk("trap_sticky", trap, 1);
            chk("trap_enables", {pc_write, ir_write, mem_read, mem_write, reg_write}, 0);
        end
        do_reset();
        chk("trap_cleared", trap, 0);

        // illegal funct
        start_instr(6'h00, 6'h03);
        cyc(1'b0, 1'b0); chk("illfunct_trap", state, 12);
        do_reset();

        // fetch timeout: 15 waiting cycles, then TRAP
        for (int i = 2; i <= 15; i++) cyc(1'b0, 1'b0);
        chk("timeout_last_wait", state, 0);
        cyc(1'b0, 1'b0); chk("timeout_trap", state, 12);
        chk("timeout_trap_flag", trap, 1);
        do_reset();

        // mem_ready arriving on the 15th cycle wins
        opcode = 6'h08; funct = 6'h00;
        for (int i = 2; i <= 14; i++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); chk("late_ready_fetch", state, 0);
        chk("late_ready_pc_write", pc_write, 1);
        cyc(1'b0, 1'b0); chk("late_ready_decode", state, 1);
        chk("late_ready_no_trap", trap, 0);
        cyc(1'b0, 1'b0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
